// File: rtl/piso_shift_transmitter_pkg.sv
// Shared types and defaults for the shift-register transmit/receive path.
// Also imported by the serial-in register bench, so keep it dependency-free.
package shift_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_t;

    localparam int SHIFT_WIDTH_DEF = 8;

endpackage

// File: rtl/piso_shift_transmitter_bit_counter.sv
// Bit-position counter for the transmitter: counts bits already on the wire
// and saturates at WIDTH-1 so it can never wrap inside a frame.
module bit_counter #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     inc,
    output logic [$clog2(WIDTH)-1:0] cnt,
    output logic                     at_last
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    // Counter register: clear has priority over increment, hold at the last index.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= {CW{1'b0}};
        end else if (clear) begin
            cnt <= {CW{1'b0}};
        end else if (inc && !at_last) begin
            cnt <= cnt + CW'(1);
        end else begin
            cnt <= cnt;
        end
    end

    assign at_last = (cnt == LAST_IDX);

endmodule

// File: rtl/piso_shift_transmitter.sv
// Parallel-in, serial-out transmitter: accepts a word on a valid/ready
// handshake and streams it out one bit per clock with a frame-end marker.
module piso_shift_transmitter
    import shift_pkg::*;
#(
    parameter int WIDTH     = SHIFT_WIDTH_DEF,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             last
);

    localparam int CW = $clog2(WIDTH);

    tx_state_t        state_r;
    tx_state_t        state_nxt_s;
    logic [WIDTH-1:0] sreg_r;
    logic [WIDTH-1:0] sreg_nxt_s;
    logic [WIDTH-1:0] shifted_s;
    logic [CW-1:0]    cnt_s;
    logic             at_last_s;
    logic             accept_s;
    logic             clear_s;
    logic             inc_s;

    bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear_s),
        .inc     (inc_s),
        .cnt     (cnt_s),
        .at_last (at_last_s)
    );

    // Handshake and counter control; a new word may land on the final bit cycle.
    always_comb begin
        load_ready = reset && ((state_r == IDLE) || ((state_r == SHIFT) && at_last_s));
        accept_s   = load_valid && load_ready;
        clear_s    = accept_s || ((state_r == SHIFT) && at_last_s);
        inc_s      = (state_r == SHIFT) && !at_last_s;
        if (MSB_FIRST) begin
            shifted_s = {sreg_r[WIDTH-2:0], 1'b0};
        end else begin
            shifted_s = {1'b0, sreg_r[WIDTH-1:1]};
        end
    end

    // Next-state and shift-register update.
    always_comb begin
        state_nxt_s = state_r;
        sreg_nxt_s  = sreg_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = SHIFT;
                    sreg_nxt_s  = load_data;
                end else begin
                    state_nxt_s = IDLE;
                    sreg_nxt_s  = sreg_r;
                end
            end
            SHIFT: begin
                if (!at_last_s) begin
                    state_nxt_s = SHIFT;
                    sreg_nxt_s  = shifted_s;
                end else if (accept_s) begin
                    state_nxt_s = SHIFT;
                    sreg_nxt_s  = load_data;
                end else begin
                    state_nxt_s = IDLE;
                    sreg_nxt_s  = {WIDTH{1'b0}};
                end
            end
            default: begin
                state_nxt_s = IDLE;
                sreg_nxt_s  = {WIDTH{1'b0}};
            end
        endcase
    end

    // State and data registers; reset discards any frame in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
            sreg_r  <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            sreg_r  <= sreg_nxt_s;
        end
    end

    // Serial outputs depend only on registered state, never on the inputs.
    always_comb begin
        if (state_r == SHIFT) begin
            sout       = MSB_FIRST ? sreg_r[WIDTH-1] : sreg_r[0];
            sout_valid = 1'b1;
            last       = at_last_s;
        end else begin
            sout       = 1'b0;
            sout_valid = 1'b0;
            last       = 1'b0;
        end
    end

endmodule

// File: tb/tb_piso_shift_transmitter.sv
// Self-checking bench: MSB-first and LSB-first transmitters driven in parallel,
// compared every cycle against a frame-level model plus literal frame checks.
module tb_piso_shift_transmitter;

    localparam int W = 8;

    logic         clk        = 1'b0;
    logic         reset      = 1'b0;
    logic         load_valid = 1'b0;
    logic [W-1:0] load_data  = 8'h00;

    logic lr_m, so_m, sv_m, la_m;
    logic lr_l, so_l, sv_l, la_l;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    piso_shift_transmitter #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
        .load_ready(lr_m), .sout(so_m), .sout_valid(sv_m), .last(la_m)
    );

    piso_shift_transmitter #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
        .load_ready(lr_l), .sout(so_l), .sout_valid(sv_l), .last(la_l)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-level model: which word is on the wire and which bit position is showing.
    logic         m_active = 1'b0;
    int           m_idx    = 0;
    logic [W-1:0] m_word   = 8'h00;
    logic         exp_ready;
    assign exp_ready = reset && (!m_active || (m_idx == W - 1));

    always @(posedge clk) begin
        if (!reset) begin
            m_active <= 1'b0;
            m_idx    <= 0;
            m_word   <= 8'h00;
        end else if (load_valid && exp_ready) begin
            m_active <= 1'b1;
            m_idx    <= 0;
            m_word   <= load_data;
        end else if (m_active) begin
            if (m_idx == W - 1) begin
                m_active <= 1'b0;
                m_idx    <= 0;
            end else begin
                m_idx <= m_idx + 1;
            end
        end
    end

    // Loopback receivers clocked on the same edges as the transmitters.
    logic [W-1:0] rx_m = 8'h00;
    logic [W-1:0] rx_l = 8'h00;
    always @(posedge clk) begin
        if (sv_m) rx_m <= {rx_m[W-2:0], so_m};
        if (sv_l) rx_l <= {so_l, rx_l[W-1:1]};
    end

    logic [63:0] cap_m = 64'h0;
    logic [63:0] cap_l = 64'h0;
    int nb_m = 0, nb_l = 0, nl_m = 0, nl_l = 0;

    // Per-cycle compare against the model, plus bit/last capture for frame checks.
    initial begin
        logic e_so_m, e_so_l, e_last;
        forever begin
            @(negedge clk);
            e_so_m = m_active ? m_word[W-1-m_idx] : 1'b0;
            e_so_l = m_active ? m_word[m_idx] : 1'b0;
            e_last = m_active && (m_idx == W - 1);
            check("m_ready", lr_m, exp_ready);
            check("m_sout", so_m, e_so_m);
            check("m_valid", sv_m, m_active);
            check("m_last", la_m, e_last);
            check("l_ready", lr_l, exp_ready);
            check("l_sout", so_l, e_so_l);
            check("l_valid", sv_l, m_active);
            check("l_last", la_l, e_last);
            if (sv_m) begin cap_m = {cap_m[62:0], so_m}; nb_m++; end
            if (sv_l) begin cap_l = {cap_l[62:0], so_l}; nb_l++; end
            if (la_m) nl_m++;
            if (la_l) nl_l++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d);
        load_valid = 1'b1;
        load_data  = d;
        tick();
        load_valid = 1'b0;
    endtask

    initial begin
        int b, bl;
        // Reset held with a word presented: nothing may start.
        reset = 1'b0; load_valid = 1'b1; load_data = 8'hA5;
        repeat (3) tick();
        check("rst_no_bits", 64'(nb_m), 64'd0);
        check("rst_no_last", 64'(nl_m), 64'd0);
        reset = 1'b1; load_valid = 1'b0;
        @(negedge clk);
        #1;
        check("ready_after_release", lr_m, 1'b1);
        tick();

        // Single frame A5.
        b = nb_m; bl = nl_m;
        send(8'hA5);
        repeat (10) tick();
        check("a5_bits", 64'(nb_m - b), 64'd8);
        check("a5_word_m", cap_m[7:0], 8'hA5);
        check("a5_word_l", cap_l[7:0], 8'hA5);
        check("a5_last", 64'(nl_m - bl), 64'd1);

        // Back-to-back A5 then 3C, second word held until the last cycle.
        b = nb_m; bl = nl_m;
        send(8'hA5);
        load_valid = 1'b1; load_data = 8'h3C;
        repeat (8) tick();
        load_valid = 1'b0;
        repeat (10) tick();
        check("b2b_bits", 64'(nb_m - b), 64'd16);
        check("b2b_word_m", cap_m[15:0], 16'hA53C);
        check("b2b_word_l", cap_l[15:0], 16'hA53C);
        check("b2b_last", 64'(nl_l - bl), 64'd2);

        // Busy ignore: 0F offered mid-frame, taken only on the final bit.
        b = nb_m; bl = nl_m;
        send(8'hF0);
        tick();
        load_valid = 1'b1; load_data = 8'h0F;
        repeat (7) tick();
        load_valid = 1'b0;
        repeat (10) tick();
        check("busy_bits", 64'(nb_m - b), 64'd16);
        check("busy_word_m", cap_m[15:0], 16'hF00F);
        check("busy_word_l", cap_l[15:0], 16'h0FF0);
        check("busy_last", 64'(nl_m - bl), 64'd2);

        // Mid-frame reset aborts FF after four bits, then 81 goes out cleanly.
        b = nb_m; bl = nl_m;
        send(8'hFF);
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        repeat (2) tick();
        check("abort_bits", 64'(nb_m - b), 64'd4);
        check("abort_word", cap_m[3:0], 4'hF);
        check("abort_no_last", 64'(nl_m - bl), 64'd0);
        b = nb_m; bl = nl_m;
        send(8'h81);
        repeat (10) tick();
        check("post_bits", 64'(nb_m - b), 64'd8);
        check("post_word_m", cap_m[7:0], 8'h81);
        check("post_word_l", cap_l[7:0], 8'h81);
        check("post_last", 64'(nl_m - bl), 64'd1);

        // 01 with loopback into serial-in receivers.
        send(8'h01);
        repeat (8) tick();
        check("loop_rx_l", rx_l, 8'h01);
        check("loop_rx_m", rx_m, 8'h01);
        repeat (4) tick();
        check("lsb_order_l", cap_l[7:0], 8'h80);
        check("msb_order_m", cap_m[7:0], 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
